// File: rtl/comparator_exerciser.sv
// Comparator exerciser: drives a fixed five-vector (a,b) sequence into an
// external 1-bit comparator, holds each vector for HOLD_CYCLES cycles, samples
// the comparator output on the last cycle of each hold, and reports the
// mismatch count and the index of the first failing vector.
module comparator_exerciser #(
  parameter int unsigned HOLD_CYCLES = 10  // legal range 2..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] exp_sel,
  output logic       a_out,
  output logic       b_out,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [2:0] first_fail_idx,
  output logic [2:0] vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_TICK = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] LAST_VEC  = 3'd4;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_timer;
  logic [2:0] r_vec_idx;
  logic [2:0] r_err_count;
  logic [2:0] r_first_fail;
  logic [1:0] r_exp_sel;
  logic       r_a;
  logic       r_b;

  logic       w_start_ok;
  logic       w_sample;
  logic       w_last_vec;
  logic       w_expected;
  logic       w_mismatch;
  logic [2:0] w_vec_next;
  logic [1:0] w_next_ab;

  // NOTE: the vector table is constant logic, so there is no storage to reset or initialise.
  function automatic logic [1:0] table_ab(input logic [2:0] idx);
    case (idx)
      3'd1:    table_ab = 2'b10;  // (a,b) = (1,0)
      3'd2:    table_ab = 2'b01;  // (a,b) = (0,1)
      3'd3:    table_ab = 2'b11;  // (a,b) = (1,1)
      default: table_ab = 2'b00;  // idx0 and idx4 are (0,0)
    endcase
  endfunction

  // Expected comparator response for the vector currently on a_out/b_out.
  function automatic logic expected_bit(input logic [1:0] sel, input logic a, input logic b);
    case (sel)
      2'd1:    expected_bit = a & ~b;   // a > b
      2'd2:    expected_bit = ~a & b;   // a < b
      default: expected_bit = a ~^ b;   // equality; code 3 is reserved and aliases to it
    endcase
  endfunction

  // Start is only honoured when no run is in flight.
  assign w_start_ok = start && (r_state != S_APPLY);
  // Compare only on the final hold cycle so the comparator has settled.
  assign w_sample   = (r_state == S_APPLY) && (r_timer == LAST_TICK);
  assign w_last_vec = (r_vec_idx == LAST_VEC);
  assign w_expected = expected_bit(r_exp_sel, r_a, r_b);
  assign w_mismatch = w_sample && (dut_out != w_expected);
  assign w_vec_next = r_vec_idx + 3'd1;
  assign w_next_ab  = table_ab(w_vec_next);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_APPLY;
      S_APPLY: if (w_sample && w_last_vec) w_next_state = S_DONE;
      S_DONE:  if (start) w_next_state = S_APPLY;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_APPLY: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    pass = done && (r_err_count == 3'd0);
  end

  // Run datapath: vector sequencing, hold timer, registered stimulus, error tally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer      <= 8'd0;
      r_vec_idx    <= 3'd0;
      r_err_count  <= 3'd0;
      r_first_fail <= 3'd0;
      r_exp_sel    <= 2'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
    end else if (w_start_ok) begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
      r_timer      <= 8'd0;
      r_vec_idx    <= 3'd0;
      r_err_count  <= 3'd0;
      r_first_fail <= 3'd0;
      r_exp_sel    <= exp_sel;
      {r_a, r_b}   <= table_ab(3'd0);
    end else if (r_state == S_APPLY) begin
      // A mismatch on the final vector still counts before DONE is entered.
      if (w_mismatch) begin
        r_err_count <= r_err_count + 3'd1;
        if (r_err_count == 3'd0) begin
          r_first_fail <= r_vec_idx;
        end
      end
      if (w_sample) begin
        r_timer <= 8'd0;
        if (w_last_vec) begin
          {r_a, r_b} <= 2'b00;
        end else begin
          r_vec_idx  <= w_vec_next;
          {r_a, r_b} <= w_next_ab;
        end
      end else begin
        r_timer <= r_timer + 8'd1;
      end
    end
  end

  assign a_out          = r_a;
  assign b_out          = r_b;
  assign err_count      = r_err_count;
  assign first_fail_idx = r_first_fail;
  assign vec_idx        = r_vec_idx;

endmodule

// File: tb/tb_comparator_exerciser.sv
// Bench for comparator_exerciser: a bench-side comparator model feeds dut_out,
// a cycle-count model predicts every output, and directed runs pin totals.
module tb_comparator_exerciser;

  localparam int H = 10;

  typedef enum int {K_XNOR, K_STUCK0, K_ANDNB, K_GLITCH} kind_e;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] exp_sel;
  logic       a_out;
  logic       b_out;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [2:0] first_fail_idx;
  logic [2:0] vec_idx;

  comparator_exerciser #(.HOLD_CYCLES(H)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .exp_sel        (exp_sel),
    .a_out          (a_out),
    .b_out          (b_out),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx),
    .vec_idx        (vec_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  bit tab_a [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  bit tab_b [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  kind_e      kind = K_XNOR;
  kind_e      m_kind = K_XNOR;
  logic [1:0] m_sel = 2'd0;
  bit         m_running = 1'b0;
  bit         m_done = 1'b0;
  int         m_k = 0;   // cycles elapsed since the accepting edge

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit golden(input kind_e k, input bit a, input bit b);
    case (k)
      K_STUCK0: golden = 1'b0;
      K_ANDNB:  golden = a & ~b;
      default:  golden = (a == b);
    endcase
  endfunction

  function automatic bit expct(input logic [1:0] sel, input bit a, input bit b);
    if (sel == 2'd1)      expct = (a > b);
    else if (sel == 2'd2) expct = (a < b);
    else                  expct = (a == b);
  endfunction

  // Mismatches among the first nvec vectors of the captured run.
  function automatic void model_errs(input int nvec, output int e, output int f);
    e = 0;
    f = 0;
    for (int v = 0; v < nvec; v++) begin
      if (golden(m_kind, tab_a[v], tab_b[v]) != expct(m_sel, tab_a[v], tab_b[v])) begin
        if (e == 0) f = v;
        e++;
      end
    end
  endfunction

  // Comparator under test, with an optional glitch on all but the last hold cycle.
  always_comb begin
    dut_out = golden(kind, a_out, b_out);
    if (kind == K_GLITCH && m_running && (m_k % H) != H - 1) dut_out = ~dut_out;
  end

  // Run model: a run lasts 5*H cycles after the accepting edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_running <= 1'b0;
      m_done    <= 1'b0;
      m_k       <= 0;
    end else if (!m_running && start) begin
      m_running <= 1'b1;
      m_done    <= 1'b0;
      m_k       <= 0;
      m_kind    <= kind;
      m_sel     <= exp_sel;
    end else if (m_running) begin
      m_k <= m_k + 1;
      if (m_k + 1 == 5 * H) begin
        m_running <= 1'b0;
        m_done    <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    int e, f, nvec, v;
    if (!rst) begin
      nvec = m_running ? (m_k / H) : (m_done ? 5 : 0);
      model_errs(nvec, e, f);
      check("busy", busy, m_running);
      check("done", done, m_done);
      check("pass", pass, (m_done && e == 0));
      check("err_count", err_count, e);
      if (e != 0) check("first_fail_idx", first_fail_idx, f);
      if (m_running) begin
        v = m_k / H;
        check("vec_idx", vec_idx, v);
        check("a_out", a_out, tab_a[v]);
        check("b_out", b_out, tab_b[v]);
      end else begin
        check("a_out_idle", a_out, 0);
        check("b_out_idle", b_out, 0);
        if (!m_done) check("vec_idx_idle", vec_idx, 0);
      end
    end
  end

  // Called at a negedge: raises start (and releases rst) then follows the run.
  task automatic run(input kind_e k, input logic [1:0] sel, input int pulse_at,
                     input int abort_at, output int busy_cycles);
    bit finished;
    busy_cycles = 0;
    finished    = 1'b0;
    kind        = k;
    exp_sel     = sel;
    rst         = 1'b0;
    start       = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (busy) busy_cycles++;
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_a_out", a_out, 0);
        check("rst_b_out", b_out, 0);
        check("rst_err_count", err_count, 0);
        check("rst_first_fail_idx", first_fail_idx, 0);
        check("rst_vec_idx", vec_idx, 0);
        return;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) check("run_timeout", 0, 1);
  endtask

  initial begin
    int bc;
    rst     = 1'b1;
    start   = 1'b0;
    exp_sel = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err_count", err_count, 0);
    check("reset_vec_idx", vec_idx, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Equality comparator, equality expectation.
    run(K_XNOR, 2'd0, -1, -1, bc);
    check("eq_busy_cycles", bc, 5 * H);
    check("eq_pass", pass, 1);
    check("eq_err_count", err_count, 0);

    // Stuck-at-0 fails idx0, idx3, idx4.
    @(negedge clk);
    run(K_STUCK0, 2'd0, -1, -1, bc);
    check("stuck_err_count", err_count, 3);
    check("stuck_first_fail", first_fail_idx, 0);
    check("stuck_pass", pass, 0);

    // a&~b against a>b passes, against a<b fails idx1 and idx2.
    @(negedge clk);
    run(K_ANDNB, 2'd1, -1, -1, bc);
    check("gt_pass", pass, 1);
    @(negedge clk);
    run(K_ANDNB, 2'd2, -1, -1, bc);
    check("lt_err_count", err_count, 2);
    check("lt_first_fail", first_fail_idx, 1);

    // Reserved selector behaves as equality.
    @(negedge clk);
    run(K_XNOR, 2'd3, -1, -1, bc);
    check("sel3_pass", pass, 1);

    // Wrong on every cycle except the sampling one.
    @(negedge clk);
    run(K_GLITCH, 2'd0, -1, -1, bc);
    check("glitch_pass", pass, 1);

    // Abort mid-hold of idx2, then restart on the cycle reset releases.
    @(negedge clk);
    run(K_STUCK0, 2'd0, -1, 25, bc);
    @(negedge clk);
    run(K_XNOR, 2'd0, -1, -1, bc);
    check("post_rst_busy_cycles", bc, 5 * H);
    check("post_rst_pass", pass, 1);

    // Start during APPLY is ignored; start from DONE clears a failing result.
    @(negedge clk);
    run(K_STUCK0, 2'd0, 20, -1, bc);
    check("ignored_start_busy_cycles", bc, 5 * H);
    check("ignored_start_err_count", err_count, 3);
    @(negedge clk);
    run(K_XNOR, 2'd0, -1, -1, bc);
    check("restart_err_count", err_count, 0);
    check("restart_pass", pass, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_exerciser.md
COMPARATOR_EXERCISER -- requirements
Module: comparator_exerciser

Interface
REQ-001 Parameter HOLD_CYCLES, default 10, SHALL set cycles each input vector is held (100 ns at 100 MHz); legal range 2..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 start  input  1  SHALL request a test run; sampled in IDLE or DONE only.
REQ-005 exp_sel  input  2  SHALL select expected function: 0 equality (a==b), 1 a>b, 2 a<b, 3 reserved (treated as 0); captured on accepted start.
REQ-006 a_out  output  1  SHALL drive comparator input a.
REQ-007 b_out  output  1  SHALL drive comparator input b.
REQ-008 dut_out  input  1  SHALL carry the comparator output under test.
REQ-009 busy  output  1  SHALL be high while a run is in progress.
REQ-010 done  output  1  SHALL be high in DONE state.
REQ-011 pass  output  1  SHALL be high when done=1 and err_count=0.
REQ-012 err_count  output  3  SHALL count mismatched vectors in the current run.
REQ-013 first_fail_idx  output  3  SHALL hold index of first mismatched vector; valid only when err_count!=0.
REQ-014 vec_idx  output  3  SHALL show index of vector currently applied.

Function
REQ-015 Vector table SHALL be fixed: idx0 (a,b)=(0,0), idx1 (1,0), idx2 (0,1), idx3 (1,1), idx4 (0,0).
REQ-016 FSM SHALL have states IDLE, APPLY, DONE.
REQ-017 IDLE: start=1 SHALL move to APPLY next edge with vec_idx=0, hold timer=0, err_count=0, first_fail_idx=0, exp_sel captured.
REQ-018 APPLY: a_out/b_out SHALL equal table[vec_idx] registered, stable for exactly HOLD_CYCLES cycles per vector.
REQ-019 Hold timer SHALL increment each APPLY cycle; dut_out SHALL be compared to expected in the cycle timer==HOLD_CYCLES-1 only (settling margin).
REQ-020 Expected value SHALL be computed from the applied a_out/b_out and captured exp_sel.
REQ-021 On mismatch, err_count SHALL increment by 1 on that edge; if err_count was 0, first_fail_idx SHALL load vec_idx.
REQ-022 At sample cycle with vec_idx<4: vec_idx increments, timer clears, stay APPLY.
REQ-023 At sample cycle with vec_idx==4: go DONE next edge; run length SHALL be 5*HOLD_CYCLES cycles of busy=1.
REQ-024 DONE: a_out=b_out=0, busy=0, done=1, err_count/first_fail_idx held; start=1 SHALL restart exactly as REQ-017.
REQ-025 start while in APPLY SHALL be ignored; no restart, no counter change.
REQ-026 err_count max is 5; no overflow handling beyond 3 bits required.
REQ-027 Simultaneous mismatch and last-vector sample SHALL both take effect: count updated, then DONE reflects final count.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, a_out=b_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, vec_idx=0, timer=0, independent of clk.
REQ-029 Reset asserted mid-run SHALL abort the run; no result retained; after release block waits in IDLE for start.
REQ-030 start high during the cycle rst deasserts SHALL be honoured only on the first edge with rst=0.

Verification
REQ-031 Equality: model dut_out = a XNOR b, exp_sel=0, HOLD_CYCLES=10, pulse start -> vectors (0,0),(1,0),(0,1),(1,1),(0,0) each 10 cycles, busy 50 cycles, done=1, pass=1, err_count=0.
REQ-032 Stuck-at-0 dut_out, exp_sel=0 -> err_count=3 (idx0,3,4), first_fail_idx=0, pass=0.
REQ-033 Model a&~b, exp_sel=1 -> pass=1; same model with exp_sel=2 -> err_count=2 (idx1,2), first_fail_idx=1.
REQ-034 Glitch dut_out wrong only in cycles 0..8 of each vector, correct at cycle 9 -> pass=1 (sampling point check).
REQ-035 Assert rst at vector idx2 mid-hold -> all outputs zero asynchronously, IDLE; new start gives clean full run with pass=1.
REQ-036 Pulse start during APPLY and again in DONE -> first ignored (run length unchanged), second restarts with counters cleared.
